// File: rtl/cpu_param_pkg.sv
// Shared definitions for the cpu_param core: opcode classes, FSM states and
// instruction field-position helpers derived from INS_W / REG_AW.
package cpu_param_pkg;

    localparam logic [2:0] CLS_MOV  = 3'b000;
    localparam logic [2:0] CLS_ADD  = 3'b001;
    localparam logic [2:0] CLS_SUB  = 3'b010;
    localparam logic [2:0] CLS_AND  = 3'b011;
    localparam logic [2:0] CLS_OR   = 3'b100;
    localparam logic [2:0] CLS_JMP  = 3'b101;
    localparam logic [2:0] CLS_JZ   = 3'b110;
    localparam logic [2:0] CLS_HALT = 3'b111;

    localparam int OPC_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    // Layout is opcode | rd | rs | imm, from MSB down.
    function automatic int immWidth(input int insW, input int regAw);
        return insW - OPC_W - 2 * regAw;
    endfunction

    function automatic int rdLsb(input int insW, input int regAw);
        return insW - OPC_W - regAw;
    endfunction

endpackage

// File: rtl/cpu_param_regfile.sv
// NUM_REGS x DATA_W register file: two combinational operand reads, one debug
// read and one synchronous write port; all registers clear on async reset.
module cpu_param_regfile
    import cpu_param_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddrA,
    output logic [DATA_W-1:0] o_rdataA,
    input  logic [REG_AW-1:0] i_raddrB,
    output logic [DATA_W-1:0] o_rdataB,
    input  logic [REG_AW-1:0] i_dbgSel,
    output logic [DATA_W-1:0] o_dbgData
);

    localparam int NUM_REGS = 2 ** REG_AW;

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdataA  = r_regs[i_raddrA];
    assign o_rdataB  = r_regs[i_raddrB];
    assign o_dbgData = r_regs[i_dbgSel];

endmodule

// File: rtl/cpu_param.sv
// Parametrised multi-cycle CPU: FETCH/DECODE/EXEC/WB with RAM handshake.
// Define CPU_PARAM_FLAGS_EN to add Z/C flags and the JZ instruction.
module cpu_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int REG_AW = 2,
    parameter int INS_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] addr,
    input  logic [INS_W-1:0]  ins,
    output logic              en_ram_in,
    input  logic              en_ram_out,
    output logic              halted,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    import cpu_param_pkg::*;

    localparam int IMM_W  = immWidth(INS_W, REG_AW);
    localparam int RD_LSB = rdLsb(INS_W, REG_AW);
    localparam int RS_LSB = IMM_W;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_target;
    logic [INS_W-1:0]  r_ir;
    logic [DATA_W-1:0] r_opA;
    logic [DATA_W-1:0] r_opB;
    logic [DATA_W-1:0] r_result;
    logic              r_enRamIn;
    logic              r_halted;
    logic              r_writeRd;
    logic              r_jump;

    logic [2:0]        w_cls;
    logic              w_srcReg;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs;
    logic [IMM_W-1:0]  w_imm;
    logic [DATA_W-1:0] w_rdData;
    logic [DATA_W-1:0] w_rsData;
    logic [DATA_W-1:0] w_aluRes;
    logic              w_takeJump;
    logic              w_we;

    assign w_cls    = r_ir[INS_W-1 -: 3];
    assign w_srcReg = r_ir[INS_W-OPC_W];
    assign w_rd     = r_ir[RD_LSB +: REG_AW];
    assign w_rs     = r_ir[RS_LSB +: REG_AW];
    assign w_imm    = r_ir[IMM_W-1:0];
    assign w_we     = (r_state == ST_WB) && r_writeRd;

    cpu_param_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_we      (w_we),
        .i_waddr   (w_rd),
        .i_wdata   (r_result),
        .i_raddrA  (w_rd),
        .o_rdataA  (w_rdData),
        .i_raddrB  (w_rs),
        .o_rdataB  (w_rsData),
        .i_dbgSel  (dbg_sel),
        .o_dbgData (dbg_data)
    );

    always_comb begin
        w_aluRes = r_opB;
        case (w_cls)
            CLS_ADD: w_aluRes = r_opA + r_opB;
            CLS_SUB: w_aluRes = r_opA - r_opB;
            CLS_AND: w_aluRes = r_opA & r_opB;
            CLS_OR:  w_aluRes = r_opA | r_opB;
            default: w_aluRes = r_opB;
        endcase
    end

`ifdef CPU_PARAM_FLAGS_EN
    logic r_z;
    logic r_c;
    logic w_carry;

    // A wrapped sum is smaller than either addend; SUB borrows when rd < src.
    always_comb begin
        w_carry = 1'b0;
        if (w_cls == CLS_ADD) begin
            w_carry = (w_aluRes < r_opA);
        end else if (w_cls == CLS_SUB) begin
            w_carry = (r_opA < r_opB);
        end
    end

    assign w_takeJump = (w_cls == CLS_JMP) || ((w_cls == CLS_JZ) && r_z);
`else
    assign w_takeJump = (w_cls == CLS_JMP);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_result  <= '0;
            r_target  <= '0;
            r_enRamIn <= 1'b0;
            r_halted  <= 1'b0;
            r_writeRd <= 1'b0;
            r_jump    <= 1'b0;
`ifdef CPU_PARAM_FLAGS_EN
            r_z       <= 1'b0;
            r_c       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_enRamIn <= 1'b1;
                    r_state   <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (en_ram_out) begin
                        r_ir      <= ins;
                        r_enRamIn <= 1'b0;
                        r_state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_opA   <= w_rdData;
                    r_opB   <= w_srcReg ? w_rsData : DATA_W'(w_imm);
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_result  <= w_aluRes;
                    r_writeRd <= (w_cls <= CLS_OR);
                    r_jump    <= w_takeJump;
                    r_target  <= ADDR_W'(r_opB);
`ifdef CPU_PARAM_FLAGS_EN
                    if (w_cls <= CLS_OR) begin
                        r_z <= (w_aluRes == '0);
                        r_c <= w_carry;
                    end
`endif
                    if (w_cls == CLS_HALT) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end else begin
                        r_state  <= ST_WB;
                    end
                end
                ST_WB: begin
                    r_pc      <= r_jump ? r_target : r_pc + 1'b1;
                    r_enRamIn <= 1'b1;
                    r_state   <= ST_FETCH;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign addr      = r_pc;
    assign en_ram_in = r_enRamIn;
    assign halted    = r_halted;

endmodule
